// File: rtl/aes128_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes128_encrypt_iter
// Iterative AES-128 encryption core. Accepts one plaintext/key pair per
// valid/ready handshake. Round keys are expanded on the fly. The core runs
// ROUNDS_PER_CYCLE rounds per clock and returns the ciphertext through a
// valid/ready output handshake.
//
// Parameters:
//   ROUNDS_PER_CYCLE  rounds executed per clock; legal values are 1, 2, 5, 10.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            synchronous active-high reset, highest priority
//   inValid        plaintext/key pair valid
//   inReady        core can accept a block (decoded from IDLE)
//   dataToOperate  plaintext, byte 0 = bits[127:120], column-major
//   keyToOperate   cipher key, same byte order
//   outValid       opRetValue holds a completed ciphertext
//   outReady       consumer accepts opRetValue
//   opRetValue     ciphertext, same byte order
//   busy           high while in RUN or DONE
//   blkCount       completed-handshake counter (only with AES128_BLKCNT_EN)
//
// Optional feature macro: AES128_BLKCNT_EN
// ---------------------------------------------------------------------------
module aes128_encrypt_iter #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] dataToOperate,
    input  logic [127:0] keyToOperate,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] opRetValue,
    output logic         busy
`ifdef AES128_BLKCNT_EN
    ,
    output logic [31:0]  blkCount
`endif
);

    localparam int unsigned NUM_RUN_CYCLES =
        (ROUNDS_PER_CYCLE == 0) ? 0 : 10 / ROUNDS_PER_CYCLE;
    localparam int unsigned RND_W = 4;
    localparam int unsigned BLK_W = 128;

    // Only exact divisors of 10 rounds are supported.
    if (ROUNDS_PER_CYCLE == 0 || ROUNDS_PER_CYCLE > 10 ||
        NUM_RUN_CYCLES * ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
        $error("aes128_encrypt_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // ---------------------------------------------------------------- GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, maps 0 to 0) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One step of the key schedule: w0..w3 -> next four words.
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // SubBytes fused with ShiftRows: out[r][c] = S(in[r][(c+r)%4]).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
            o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // ---------------------------------------------------------------- state
    state_e             fsm_q;
    logic [BLK_W-1:0]   aes_q, aes_d;
    logic [BLK_W-1:0]   rk_q, rk_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [BLK_W-1:0]   result_q;
    logic               out_valid_q;
`ifdef AES128_BLKCNT_EN
    logic [31:0]        blk_cnt_q;
`endif

    logic [BLK_W-1:0]   st_c   [ROUNDS_PER_CYCLE+1];
    logic [BLK_W-1:0]   key_c  [ROUNDS_PER_CYCLE+1];
    logic [7:0]         rcon_c [ROUNDS_PER_CYCLE+1];

    // Chain ROUNDS_PER_CYCLE rounds; the tenth round has no MixColumns.
    always_comb begin
        st_c[0]   = aes_q;
        key_c[0]  = rk_q;
        rcon_c[0] = rcon_q;
        for (int unsigned k = 0; k < ROUNDS_PER_CYCLE; k++) begin
            logic [BLK_W-1:0] ss;
            key_c[k+1]  = next_key(key_c[k], rcon_c[k]);
            rcon_c[k+1] = xtime(rcon_c[k]);
            ss          = sub_shift(st_c[k]);
            if ((rnd_q + RND_W'(k + 1)) != RND_W'(10)) begin
                ss = mix_columns(ss);
            end
            st_c[k+1] = ss ^ key_c[k+1];
        end
        aes_d  = st_c[ROUNDS_PER_CYCLE];
        rk_d   = key_c[ROUNDS_PER_CYCLE];
        rcon_d = rcon_c[ROUNDS_PER_CYCLE];
        rnd_d  = rnd_q + RND_W'(ROUNDS_PER_CYCLE);
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q       <= S_IDLE;
            aes_q       <= '0;
            rk_q        <= '0;
            rcon_q      <= 8'h01;
            rnd_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef AES128_BLKCNT_EN
            blk_cnt_q   <= '0;
`endif
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (inValid) begin
                        aes_q  <= dataToOperate ^ keyToOperate;
                        rk_q   <= keyToOperate;
                        rcon_q <= 8'h01;
                        rnd_q  <= '0;
                        fsm_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    aes_q  <= aes_d;
                    rk_q   <= rk_d;
                    rcon_q <= rcon_d;
                    rnd_q  <= rnd_d;
                    if (rnd_d == RND_W'(10)) begin
                        result_q    <= aes_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (outReady) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= S_IDLE;
`ifdef AES128_BLKCNT_EN
                        blk_cnt_q   <= blk_cnt_q + 32'd1;
`endif
                    end
                end
                default: begin
                    fsm_q       <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign inReady    = (fsm_q == S_IDLE);
    assign busy       = (fsm_q != S_IDLE);
    assign outValid   = out_valid_q;
    assign opRetValue = result_q;
`ifdef AES128_BLKCNT_EN
    assign blkCount   = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: four instances (RPC 1/2/5/10)
// share the input side; RPC=1 carries the table-driven and corner-case checks.
module tb_aes128_encrypt_iter;

    logic         CLK = 1'b0;
    logic         RST;
    logic         inValid;
    logic         outReady;
    logic [127:0] dataToOperate;
    logic [127:0] keyToOperate;

    logic         in_ready  [4];
    logic         out_valid [4];
    logic         busy_w    [4];
    logic [127:0] ct_w      [4];
`ifdef AES128_BLKCNT_EN
    logic [31:0]  blk_cnt   [4];
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .inValid(inValid), .inReady(in_ready[0]),
        .dataToOperate(dataToOperate), .keyToOperate(keyToOperate),
        .outValid(out_valid[0]), .outReady(outReady), .opRetValue(ct_w[0]),
        .busy(busy_w[0])
`ifdef AES128_BLKCNT_EN
        , .blkCount(blk_cnt[0])
`endif
    );
    aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .inValid(inValid), .inReady(in_ready[1]),
        .dataToOperate(dataToOperate), .keyToOperate(keyToOperate),
        .outValid(out_valid[1]), .outReady(outReady), .opRetValue(ct_w[1]),
        .busy(busy_w[1])
`ifdef AES128_BLKCNT_EN
        , .blkCount(blk_cnt[1])
`endif
    );
    aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(5)) u_dut5 (
        .CLK(CLK), .RST(RST), .inValid(inValid), .inReady(in_ready[2]),
        .dataToOperate(dataToOperate), .keyToOperate(keyToOperate),
        .outValid(out_valid[2]), .outReady(outReady), .opRetValue(ct_w[2]),
        .busy(busy_w[2])
`ifdef AES128_BLKCNT_EN
        , .blkCount(blk_cnt[2])
`endif
    );
    aes128_encrypt_iter #(.ROUNDS_PER_CYCLE(10)) u_dut10 (
        .CLK(CLK), .RST(RST), .inValid(inValid), .inReady(in_ready[3]),
        .dataToOperate(dataToOperate), .keyToOperate(keyToOperate),
        .outValid(out_valid[3]), .outReady(outReady), .opRetValue(ct_w[3]),
        .busy(busy_w[3])
`ifdef AES128_BLKCNT_EN
        , .blkCount(blk_cnt[3])
`endif
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [6];

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Accept one block on the RPC=1 instance and wait (bounded) for outValid.
    task automatic do_block(input logic [127:0] key, input logic [127:0] pt,
                            output logic [127:0] ct, output int lat);
        keyToOperate  = key;
        dataToOperate = pt;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        lat     = 0;
        do begin
            step();
            lat++;
        end while (!out_valid[0] && lat < 40);
        ct = ct_w[0];
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] held;
        int           lat;
        int           first_seen [4];
        int           exp_lat    [4];
        int           bad;

        vecs[0] = '{K_C1, P_C1, C_C1};
        vecs[1] = '{K_B,  P_B,  C_B};
        vecs[2] = '{K_B, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[3] = '{K_B, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf};
        vecs[4] = '{K_B, 128'hf69f2445df4f9b17ad2b417be66c3710, 128'h7b0c785e27e8ad3f8223207104725dd4};
        vecs[5] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        exp_lat = '{10, 5, 2, 1};

        RST           = 1'b1;
        inValid       = 1'b0;
        outReady      = 1'b1;
        dataToOperate = '0;
        keyToOperate  = '0;
        step();
        step();
        check("rst_outValid", 128'(out_valid[0]), 128'(0));
        check("rst_inReady",  128'(in_ready[0]),  128'(1));
        check("rst_busy",     128'(busy_w[0]),    128'(0));
        check("rst_opRet",    ct_w[0],            128'(0));
        RST = 1'b0;

        // Table-driven vectors on RPC=1 with outReady held high.
        for (int i = 0; i < 6; i++) begin
            do_block(vecs[i].key, vecs[i].pt, ct, lat);
            check("tbl_latency", 128'(lat), 128'(10));
            check("tbl_ct", ct, vecs[i].ct);
            step();
            check("tbl_ov_drop", 128'(out_valid[0]), 128'(0));
            check("tbl_inReady", 128'(in_ready[0]), 128'(1));
            check("tbl_ct_kept", ct_w[0], vecs[i].ct);
        end

        // All four configurations from one accept; latency per RPC.
        outReady      = 1'b0;
        keyToOperate  = K_B;
        dataToOperate = P_B;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        check("run_inReady", 128'(in_ready[0]), 128'(0));
        check("run_busy",    128'(busy_w[0]),   128'(1));
        first_seen = '{0, 0, 0, 0};
        for (int c = 1; c <= 12; c++) begin
            for (int d = 0; d < 4; d++) begin
                if (out_valid[d] && first_seen[d] == 0) first_seen[d] = c - 1;
            end
            step();
        end
        for (int d = 0; d < 4; d++) begin
            if (out_valid[d] && first_seen[d] == 0) first_seen[d] = 12;
            check("rpc_latency", 128'(first_seen[d]), 128'(exp_lat[d]));
            check("rpc_ct", ct_w[d], C_B);
            check("rpc_busy_done", 128'(busy_w[d]), 128'(1));
        end
        outReady = 1'b1;
        step();
        for (int d = 0; d < 4; d++) begin
            check("rpc_ov_drop", 128'(out_valid[d]), 128'(0));
        end

        // Backpressure with inValid pulses in RUN and DONE.
        outReady      = 1'b0;
        keyToOperate  = K_C1;
        dataToOperate = P_C1;
        inValid       = 1'b1;
        step();
        lat = 0;
        do begin
            inValid       = lat[0];
            dataToOperate = rnd128();
            keyToOperate  = rnd128();
            step();
            lat++;
        end while (!out_valid[0] && lat < 40);
        check("bp_latency", 128'(lat), 128'(10));
        held = ct_w[0];
        check("bp_ct", held, C_C1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            inValid       = ~inValid;
            dataToOperate = rnd128();
            step();
            if (ct_w[0] !== C_C1 || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) bad++;
        end
        check("bp_hold", 128'(bad), 128'(0));
        inValid  = 1'b0;
        outReady = 1'b1;
        step();
        check("bp_ov_drop", 128'(out_valid[0]), 128'(0));
        check("bp_inReady", 128'(in_ready[0]), 128'(1));
        step();
        step();
        check("bp_no_queue", 128'(busy_w[0]), 128'(0));

        // Inputs change every cycle after accept.
        keyToOperate  = K_B;
        dataToOperate = P_B;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        lat     = 0;
        do begin
            dataToOperate = rnd128();
            keyToOperate  = rnd128();
            step();
            lat++;
        end while (!out_valid[0] && lat < 40);
        check("chg_latency", 128'(lat), 128'(10));
        check("chg_ct", ct_w[0], C_B);
        step();
        check("chg_ov_drop", 128'(out_valid[0]), 128'(0));

        // Reset at RUN cycle 4 discards the block.
        keyToOperate  = K_C1;
        dataToOperate = P_C1;
        inValid       = 1'b1;
        step();
        inValid = 1'b0;
        step();
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mrst_outValid", 128'(out_valid[0]), 128'(0));
        check("mrst_inReady",  128'(in_ready[0]),  128'(1));
        check("mrst_busy",     128'(busy_w[0]),    128'(0));
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (out_valid[0] !== 1'b0) bad++;
        end
        check("mrst_no_output", 128'(bad), 128'(0));
        do_block(K_C1, P_C1, ct, lat);
        check("mrst_next_latency", 128'(lat), 128'(10));
        check("mrst_next_ct", ct, C_C1);
        step();

`ifdef AES128_BLKCNT_EN
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("cnt_reset", 128'(blk_cnt[0]), 128'(0));
        for (int i = 0; i < 3; i++) begin
            do_block(vecs[i].key, vecs[i].pt, ct, lat);
            step();
            check("cnt_incr", 128'(blk_cnt[0]), 128'(i + 1));
        end
        u_dut1.blk_cnt_q = 32'hFFFFFFFF;
        do_block(K_B, P_B, ct, lat);
        step();
        check("cnt_wrap", 128'(blk_cnt[0]), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
